// File: rtl/tetris_dp_param.sv
// rtl/tetris_dp_param.sv - parametrised Tetris board/piece datapath with spawn, move, land, line-clear and game-over FSM
//
// Ports:
//   clka          clock, all state changes on the rising edge
//   restart       synchronous active-high reset, forces NEWBOARD
//   cmd_valid/cmd command handshake: 00 left, 01 right, 10 rotate, 11 soft drop
//   cmd_ready     high in MOVE when no gravity step is pending
//   tick          gravity pulse, only honoured in MOVE
//   piece_sel     type of the next piece, sampled in GEN
//   board_out     settled board, bit = row*COLS+col, row 0 at the top
//   frame_out     board plus active piece, all ones in GAMEOVER
//   piece_row/piece_col/rotation_out/piece_type  active piece
//   touched       one-cycle pulse when a piece is merged into the board
//   blocked       one-cycle pulse when left/right/rotate is rejected
//   lines_cleared saturating count of cleared rows
//   game_over     high in GAMEOVER
//   state_out     FSM state encoding

module tetris_dp_param #(
    parameter int COLS    = 4,
    parameter int ROWS    = 8,
    parameter int SCORE_W = 8
) (
    input  logic                    clka,
    input  logic                    restart,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd,
    output logic                    cmd_ready,
    input  logic                    tick,
    input  logic [1:0]              piece_sel,
    output logic [COLS*ROWS-1:0]    board_out,
    output logic [COLS*ROWS-1:0]    frame_out,
    output logic [$clog2(ROWS)-1:0] piece_row,
    output logic [$clog2(COLS)-1:0] piece_col,
    output logic [1:0]              rotation_out,
    output logic [1:0]              piece_type,
    output logic                    touched,
    output logic                    blocked,
    output logic [SCORE_W-1:0]      lines_cleared,
    output logic                    game_over,
    output logic [2:0]              state_out
);

    localparam int N         = COLS * ROWS;
    localparam int RW        = $clog2(ROWS);
    localparam int CW        = $clog2(COLS);
    localparam int SPAWN_COL = (COLS - 2) / 2;

    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  ALL      = {N{1'b1}};
    localparam logic [N-1:0]  ROW_ONES = ALL >> (N - COLS);
    localparam logic [RW-1:0] SCAN_TOP = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_GEN      = 3'b000,
        S_MOVE     = 3'b001,
        S_LAND     = 3'b010,
        S_CLEAR    = 3'b011,
        S_NEWBOARD = 3'b100,
        S_GAMEOVER = 3'b101
    } state_t;

    state_t            state, state_n;
    logic              grav_pend, grav_n;
    logic [RW-1:0]     scan, scan_n;
    logic [N-1:0]      board_n, frame_n, lo_mask;
    logic [RW-1:0]     row_n;
    logic [CW-1:0]     col_n;
    logic [1:0]        rot_n, type_n, next_rot;
    logic [SCORE_W-1:0] lines_n;
    logic              touched_n, blocked_n, do_down, row_full;
    logic [3:0]        cur_mask;

    // 2x2 occupancy mask, bit r*2+c; each rotation step moves (r,c) to (c,1-r)
    function automatic logic [3:0] shape_mask(input logic [1:0] ptype, input logic [1:0] rot);
        logic [3:0] m;
        case (ptype)
            2'd0:    m = 4'b1111;
            2'd1:    m = 4'b0101;
            2'd2:    m = 4'b1101;
            default: m = 4'b0001;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (i < int'(rot)) m = {m[1], m[3], m[0], m[2]};
        end
        return m;
    endfunction

    function automatic logic [N-1:0] place(input int row, input int col, input logic [3:0] m);
        logic [N-1:0] v;
        v = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                if (((m >> (r * 2 + c)) & 4'b0001) != 4'b0000 &&
                    (row + r) < ROWS && (col + c) < COLS && (col + c) >= 0)
                    v = v | (ONE << ((row + r) * COLS + col + c));
            end
        end
        return v;
    endfunction

    function automatic logic fits(input int row, input int col, input logic [3:0] m,
                                  input logic [N-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                if (((m >> (r * 2 + c)) & 4'b0001) != 4'b0000) begin
                    if ((row + r) >= ROWS || (col + c) >= COLS || (col + c) < 0)
                        ok = 1'b0;
                    else if (((b >> ((row + r) * COLS + col + c)) & ONE) != '0)
                        ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    assign cmd_ready = (state == S_MOVE) && !grav_pend;
    assign state_out = state;

    always_comb begin
        state_n   = state;
        board_n   = board_out;
        row_n     = piece_row;
        col_n     = piece_col;
        rot_n     = rotation_out;
        type_n    = piece_type;
        scan_n    = scan;
        lines_n   = lines_cleared;
        grav_n    = 1'b0;
        touched_n = 1'b0;
        blocked_n = 1'b0;
        do_down   = 1'b0;
        next_rot  = rotation_out + 2'd1;
        cur_mask  = shape_mask(piece_type, rotation_out);
        row_full  = ((board_out >> (int'(scan) * COLS)) & ROW_ONES) == ROW_ONES;
        // Rows 0..scan; shifting ALL by N (scan at the bottom row) yields zero, so every row is selected
        lo_mask   = ~(ALL << ((int'(scan) + 1) * COLS));

        case (state)
            S_NEWBOARD: begin
                board_n = '0;
                row_n   = '0;
                col_n   = '0;
                rot_n   = '0;
                type_n  = '0;
                scan_n  = '0;
                lines_n = '0;
                state_n = S_GEN;
            end
            S_GEN: begin
                type_n = piece_sel;
                row_n  = '0;
                col_n  = CW'(SPAWN_COL);
                rot_n  = '0;
                if (fits(0, SPAWN_COL, shape_mask(piece_sel, 2'd0), board_out))
                    state_n = S_MOVE;
                else
                    state_n = S_GAMEOVER;
            end
            S_MOVE: begin
                // A pending gravity step takes priority; commands are held off by cmd_ready
                if (grav_pend) begin
                    do_down = 1'b1;
                end else if (cmd_valid) begin
                    case (cmd)
                        2'b00: begin
                            if (piece_col != '0 &&
                                fits(int'(piece_row), int'(piece_col) - 1, cur_mask, board_out))
                                col_n = piece_col - 1'b1;
                            else
                                blocked_n = 1'b1;
                        end
                        2'b01: begin
                            if (fits(int'(piece_row), int'(piece_col) + 1, cur_mask, board_out))
                                col_n = piece_col + 1'b1;
                            else
                                blocked_n = 1'b1;
                        end
                        2'b10: begin
                            if (fits(int'(piece_row), int'(piece_col),
                                     shape_mask(piece_type, next_rot), board_out))
                                rot_n = next_rot;
                            else
                                blocked_n = 1'b1;
                        end
                        default: do_down = 1'b1;
                    endcase
                end
                if (do_down) begin
                    if (fits(int'(piece_row) + 1, int'(piece_col), cur_mask, board_out))
                        row_n = piece_row + 1'b1;
                    else
                        state_n = S_LAND;
                end
                grav_n = tick && (state_n == S_MOVE);
            end
            S_LAND: begin
                board_n   = board_out | place(int'(piece_row), int'(piece_col), cur_mask);
                touched_n = 1'b1;
                scan_n    = SCAN_TOP;
                state_n   = S_CLEAR;
            end
            S_CLEAR: begin
                // A full row collapses everything above it; the same row index is rescanned
                if (row_full) begin
                    board_n = (board_out & ~lo_mask) | ((board_out << COLS) & lo_mask);
                    if (lines_cleared != {SCORE_W{1'b1}})
                        lines_n = lines_cleared + 1'b1;
                end else if (scan != '0) begin
                    scan_n = scan - 1'b1;
                end else begin
                    state_n = S_GEN;
                end
            end
            S_GAMEOVER: begin
                state_n = S_GAMEOVER;
            end
            default: begin
                state_n = S_NEWBOARD;
            end
        endcase

        if (state_n == S_GAMEOVER)
            frame_n = ALL;
        else if (state_n == S_MOVE)
            frame_n = board_n | place(int'(row_n), int'(col_n), shape_mask(type_n, rot_n));
        else
            frame_n = board_n;
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state         <= S_NEWBOARD;
            grav_pend     <= 1'b0;
            scan          <= '0;
            board_out     <= '0;
            frame_out     <= '0;
            piece_row     <= '0;
            piece_col     <= '0;
            rotation_out  <= '0;
            piece_type    <= '0;
            touched       <= 1'b0;
            blocked       <= 1'b0;
            lines_cleared <= '0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            grav_pend     <= grav_n;
            scan          <= scan_n;
            board_out     <= board_n;
            frame_out     <= frame_n;
            piece_row     <= row_n;
            piece_col     <= col_n;
            rotation_out  <= rot_n;
            piece_type    <= type_n;
            touched       <= touched_n;
            blocked       <= blocked_n;
            lines_cleared <= lines_n;
            game_over     <= (state_n == S_GAMEOVER);
        end
    end

endmodule

// File: tb/tb_tetris_dp_param.sv
// tb/tb_tetris_dp_param.sv - self-checking bench for tetris_dp_param (vector table, corner sequences, random vs model)

module tb_tetris_dp_param;

    localparam int COLS = 4;
    localparam int ROWS = 8;
    localparam int SW   = 8;

    localparam logic [2:0] ST_GEN = 3'b000, ST_MOVE = 3'b001, ST_LAND = 3'b010,
                           ST_CLEAR = 3'b011, ST_NEW = 3'b100, ST_OVER = 3'b101;

    logic        clka = 1'b0;
    logic        restart, cmd_valid, tick;
    logic [1:0]  cmd, piece_sel;
    logic        cmd_ready, touched, blocked, game_over;
    logic [31:0] board_out, frame_out;
    logic [2:0]  piece_row;
    logic [1:0]  piece_col, rotation_out, piece_type;
    logic [7:0]  lines_cleared;
    logic [2:0]  state_out;

    tetris_dp_param #(.COLS(COLS), .ROWS(ROWS), .SCORE_W(SW)) dut (
        .clka(clka), .restart(restart), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .tick(tick), .piece_sel(piece_sel),
        .board_out(board_out), .frame_out(frame_out), .piece_row(piece_row),
        .piece_col(piece_col), .rotation_out(rotation_out), .piece_type(piece_type),
        .touched(touched), .blocked(blocked), .lines_cleared(lines_cleared),
        .game_over(game_over), .state_out(state_out)
    );

    always #5 clka = ~clka;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic cmd1(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick      = 1'b0;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, output int n);
        n = 0;
        while (state_out != s && n < lim) begin
            step();
            n++;
        end
    endtask

    // ---------------- behavioural model: board as a cell grid ----------------
    bit mb [ROWS][COLS];
    int mrow, mcol, mrot, mtype, mlines;
    bit mpend;

    function automatic bit base_occ(input int t, input int r, input int c);
        case (t)
            0:       return 1'b1;
            1:       return c == 0;
            2:       return !(r == 0 && c == 1);
            default: return r == 0 && c == 0;
        endcase
    endfunction

    function automatic bit occ(input int t, input int rot, input int r, input int c);
        int x, y, tmp;
        for (int br = 0; br < 2; br++)
            for (int bc = 0; bc < 2; bc++)
                if (base_occ(t, br, bc)) begin
                    x = br;
                    y = bc;
                    for (int k = 0; k < rot; k++) begin
                        tmp = x;
                        x = y;
                        y = 1 - tmp;
                    end
                    if (x == r && y == c) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic bit model_fits(input int r0, input int c0, input int t, input int rot);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                if (occ(t, rot, r, c)) begin
                    if (r0 + r >= ROWS || c0 + c >= COLS || c0 + c < 0) return 1'b0;
                    if (mb[r0 + r][c0 + c]) return 1'b0;
                end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_board();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mb[r][c]) v = v | (32'd1 << (r * COLS + c));
        return v;
    endfunction

    function automatic logic [31:0] model_frame();
        logic [31:0] v;
        v = model_board();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                if (occ(mtype, mrot, r, c)) v = v | (32'd1 << ((mrow + r) * COLS + mcol + c));
        return v;
    endfunction

    // Merge the piece, drop full rows, compact the rest downward; returns rows removed
    function automatic int model_land();
        bit nb [ROWS][COLS];
        int w, k;
        bit full;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                if (occ(mtype, mrot, r, c)) mb[mrow + r][mcol + c] = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) nb[r][c] = 1'b0;
        w = ROWS - 1;
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (!mb[r][c]) full = 1'b0;
            if (full) k++;
            else begin
                for (int c = 0; c < COLS; c++) nb[w][c] = mb[r][c];
                w--;
            end
        end
        mb = nb;
        mlines = (mlines + k > 255) ? 255 : mlines + k;
        return k;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mb[r][c] = 1'b0;
        mlines = 0;
        mpend  = 1'b0;
    endfunction

    function automatic bit model_spawn(input int sel);
        mtype = sel;
        mrow  = 0;
        mcol  = (COLS - 2) / 2;
        mrot  = 0;
        return model_fits(mrow, mcol, mtype, mrot);
    endfunction

    task automatic do_restart();
        restart   = 1'b1;
        cmd_valid = 1'b0;
        tick      = 1'b0;
        step();
        restart = 1'b0;
        step();
        step();
        model_reset();
        void'(model_spawn(int'(piece_sel)));
    endtask

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic       t;
        int         row, col, rot;
        logic       blk, rdy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, sel;
        bit v, t, land, down, blk, exp_rdy;
        logic [1:0] c;

        tbl[0]  = '{1'b1, 2'd0, 1'b0, 0, 0, 0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 0, 0, 0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 0, 1, 0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 0, 2, 0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 2'd1, 1'b0, 0, 2, 0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 0, 1, 0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'd1, 1'b1, 0, 2, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 1, 2, 0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 1, 2, 1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 2, 2, 1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 2, 2, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 3, 2, 1, 1'b0, 1'b1};

        restart   = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        tick      = 1'b0;
        piece_sel = 2'd0;

        // reset values after the restart edge
        step();
        check("rst_state", state_out, ST_NEW);
        check("rst_board", board_out, 0);
        check("rst_frame", frame_out, 0);
        check("rst_pos", {piece_row, piece_col, rotation_out, piece_type}, 0);
        check("rst_pulses", {touched, blocked, game_over}, 0);
        check("rst_lines", lines_cleared, 0);
        check("rst_ready", cmd_ready, 0);
        restart = 1'b0;
        step();
        check("gen_state", state_out, ST_GEN);
        step();
        check("move_state", state_out, ST_MOVE);
        check("spawn_rowcol", {piece_row, piece_col}, {3'd0, 2'd1});
        check("spawn_frame", frame_out, 32'h0000_0066);
        check("spawn_board", board_out, 0);

        // table of single-edge moves on the spawned square
        for (int i = 0; i < 12; i++) begin
            cmd_valid = tbl[i].v;
            cmd       = tbl[i].c;
            tick      = tbl[i].t;
            step();
            check($sformatf("vec%0d_row", i), piece_row, tbl[i].row);
            check($sformatf("vec%0d_col", i), piece_col, tbl[i].col);
            check($sformatf("vec%0d_rot", i), rotation_out, tbl[i].rot);
            check($sformatf("vec%0d_blk", i), blocked, tbl[i].blk);
            check($sformatf("vec%0d_rdy", i), cmd_ready, tbl[i].rdy);
        end
        cmd_valid = 1'b0;
        tick      = 1'b0;

        // type1 pushed to the right edge cannot rotate
        piece_sel = 2'd1;
        do_restart();
        cmd1(2'd1);
        cmd1(2'd1);
        check("t1_col3", piece_col, 3);
        cmd1(2'd2);
        check("t1_rot_blk", blocked, 1);
        check("t1_rot_keep", rotation_out, 0);
        check("t1_type", piece_type, 1);

        // square to the floor at col 0, then one at col 2 completes two rows
        piece_sel = 2'd0;
        do_restart();
        cmd1(2'd0);
        repeat (6) cmd1(2'd3);
        check("drop6_row", piece_row, 6);
        cmd1(2'd3);
        check("land_state", state_out, ST_LAND);
        check("land_touch0", touched, 0);
        step();
        check("merge_touch", touched, 1);
        check("merge_board", board_out, 32'h3300_0000);
        check("merge_state", state_out, ST_CLEAR);
        step();
        check("touch_pulse_end", touched, 0);
        wait_state(ST_MOVE, 30, n);
        check("respawn_state", state_out, ST_MOVE);
        cmd1(2'd1);
        repeat (7) cmd1(2'd3);
        step();
        check("full_board", board_out, 32'hFF00_0000);
        wait_state(ST_GEN, 40, n);
        check("clear_cycles", n, 10);
        check("clear_lines", lines_cleared, 2);
        check("clear_board", board_out, 0);

        // stack squares at the spawn column until spawn collides
        do_restart();
        for (int p = 0; p < 4; p++) begin
            wait_state(ST_MOVE, 40, n);
            n = 0;
            while (state_out == ST_MOVE && n < 20) begin
                cmd1(2'd3);
                n++;
            end
        end
        wait_state(ST_OVER, 40, n);
        check("go_state", state_out, ST_OVER);
        check("go_flag", game_over, 1);
        check("go_frame", frame_out, 32'hFFFF_FFFF);
        check("go_ready", cmd_ready, 0);
        check("go_board", board_out, 32'h6666_6666);
        cmd_valid = 1'b1;
        cmd       = 2'd3;
        tick      = 1'b1;
        step();
        cmd_valid = 1'b0;
        tick      = 1'b0;
        check("go_sticky", state_out, ST_OVER);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("go_rst_state", state_out, ST_NEW);
        check("go_rst_board", board_out, 0);
        check("go_rst_frame", frame_out, 0);
        check("go_rst_flags", {game_over, touched, blocked, cmd_ready}, 0);
        check("go_rst_lines", lines_cleared, 0);

        // random play against the grid model
        piece_sel = 2'($urandom_range(0, 3));
        do_restart();
        check("rnd_start", state_out, ST_MOVE);
        for (int it = 0; it < 700; it++) begin
            v = ($urandom_range(0, 3) != 0);
            c = 2'($urandom_range(0, 3));
            t = ($urandom_range(0, 7) == 0);
            cmd_valid = v;
            cmd       = c;
            tick      = t;
            exp_rdy = !mpend;
            land = 1'b0;
            down = 1'b0;
            blk  = 1'b0;
            if (mpend) down = 1'b1;
            else if (v) begin
                case (c)
                    2'd0: if (mcol > 0 && model_fits(mrow, mcol - 1, mtype, mrot)) mcol--; else blk = 1'b1;
                    2'd1: if (model_fits(mrow, mcol + 1, mtype, mrot)) mcol++; else blk = 1'b1;
                    2'd2: if (model_fits(mrow, mcol, mtype, (mrot + 1) % 4)) mrot = (mrot + 1) % 4; else blk = 1'b1;
                    default: down = 1'b1;
                endcase
            end
            if (down) begin
                if (model_fits(mrow + 1, mcol, mtype, mrot)) mrow++;
                else land = 1'b1;
            end
            mpend = t && !land;
            check("rnd_ready", cmd_ready, exp_rdy);
            step();
            check("rnd_blocked", blocked, blk);
            if (!land) begin
                check("rnd_state", state_out, ST_MOVE);
                check("rnd_pos", {piece_row, piece_col, rotation_out}, {3'(mrow), 2'(mcol), 2'(mrot)});
                check("rnd_frame", frame_out, model_frame());
            end else begin
                check("rnd_land", state_out, ST_LAND);
                k = model_land();
                sel = $urandom_range(0, 3);
                piece_sel = 2'(sel);
                cmd_valid = 1'b0;
                tick      = 1'b0;
                step();
                check("rnd_touched", touched, 1);
                check("rnd_clear", state_out, ST_CLEAR);
                repeat (ROWS + k) step();
                check("rnd_gen", state_out, ST_GEN);
                check("rnd_board", board_out, model_board());
                check("rnd_lines", lines_cleared, mlines);
                step();
                if (model_spawn(sel)) begin
                    check("rnd_spawn", state_out, ST_MOVE);
                    check("rnd_spawn_pos", {piece_row, piece_col, rotation_out, piece_type},
                          {3'd0, 2'(mcol), 2'd0, 2'(sel)});
                    check("rnd_spawn_frame", frame_out, model_frame());
                end else begin
                    check("rnd_over", state_out, ST_OVER);
                    check("rnd_over_frame", frame_out, 32'hFFFF_FFFF);
                    piece_sel = 2'($urandom_range(0, 3));
                    do_restart();
                    check("rnd_restart", state_out, ST_MOVE);
                end
            end
        end
        cmd_valid = 1'b0;
        tick      = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
